mul_booth_seq: RTL and testbench

Sequential 32×32→64 multiplier using radix-4 Booth recoding. It is the multiply counterpart of the team's sequential divider and shares the same start/ready handshake. It sits in the ALU datapath and delivers the full 64-bit product as separate HI and LO words, one recoded digit per clock, so the critical path stays comparable to the divider's subtract stage.

---
 rtl/mul_booth_seq_pkg.sv | 50 +++++
 rtl/mul_booth_seq_if.sv | 23 ++
 rtl/mul_booth_seq_booth_r4_enc.sv | 22 ++
 rtl/mul_booth_seq.sv | 103 ++++++++++
 tb/tb_mul_booth_seq.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_booth_seq_pkg.sv
// Shared constants and types for the radix-4 Booth sequential multiplier.
// Build option: define MUL_SIGNED_EN for two's-complement operands
// (16 iterations); leave it undefined for unsigned operands (17 iterations).
package mul_pkg;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 34;

`ifdef MUL_SIGNED_EN
    localparam int N_ITER = 16;
`else
    localparam int N_ITER = 17;
`endif

    // Width of the multiplier shift register: two bits retire per iteration
    localparam int Q_W   = 2 * N_ITER;
    localparam int CNT_W = $clog2(N_ITER + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_sel_t;

    // Widen the multiplicand to the partial-sum width
    function automatic logic [ACC_W-1:0] ext_m(input logic [DATA_W-1:0] v);
`ifdef MUL_SIGNED_EN
        return {{(ACC_W - DATA_W){v[DATA_W-1]}}, v};
`else
        return {{(ACC_W - DATA_W){1'b0}}, v};
`endif
    endfunction

    // Widen the multiplier so the final triplet recodes its extension
    function automatic logic [Q_W-1:0] ext_q(input logic [DATA_W-1:0] v);
`ifdef MUL_SIGNED_EN
        return v;
`else
        return {{(Q_W - DATA_W){1'b0}}, v};
`endif
    endfunction

endpackage

// File: rtl/mul_booth_seq_if.sv
// Start/ready handshake and operand/product bus of the Booth multiplier.
interface mul_booth_seq_if;
    import mul_pkg::*;

    logic              start;
    logic [DATA_W-1:0] M;
    logic [DATA_W-1:0] Q;
    logic [DATA_W-1:0] product_hi;
    logic [DATA_W-1:0] product_lo;
    logic              ready;
    logic              done;

    modport master (
        output start, M, Q,
        input  product_hi, product_lo, ready, done
    );

    modport slave (
        input  start, M, Q,
        output product_hi, product_lo, ready, done
    );

endinterface

// File: rtl/mul_booth_seq_booth_r4_enc.sv
// Radix-4 Booth digit recoder: {q[2i+1], q[2i], q[2i-1]} -> signed multiple select.
module booth_r4_enc
    import mul_pkg::*;
(
    input  logic [2:0] triplet,
    output booth_sel_t sel
);

    // Map each overlapping bit triplet to one of the five Booth multiples
    always_comb begin
        sel = ZERO;
        case (triplet)
            3'b000, 3'b111: sel = ZERO;
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100:         sel = NEG2;
            3'b101, 3'b110: sel = NEG1;
            default:        sel = ZERO;
        endcase
    end

endmodule

// File: rtl/mul_booth_seq.sv
// Sequential 32x32->64 radix-4 Booth multiplier, one recoded digit per clock.
// Build option MUL_SIGNED_EN selects signed operands (16 iterations);
// undefined gives unsigned operands (17 iterations).
// The running product lives in {acc_hi, acc_lo, q_m1}: acc_hi is the 34-bit
// partial sum, acc_lo starts as the extended multiplier and fills with
// retired product bits from the top as the multiplier bits drain out the bottom.
module mul_booth_seq
    import mul_pkg::*;
(
    input  logic clk,
    input  logic reset,
    mul_booth_seq_if.slave bus
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  m_ext;
    logic [ACC_W-1:0]  acc_hi;
    logic [Q_W-1:0]    acc_lo;
    logic              q_m1;

    booth_sel_t        sel;
    logic [ACC_W-1:0]  term;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  hi_next;
    logic [Q_W-1:0]    lo_next;
    logic [63:0]       prod_next;

    booth_r4_enc u_enc (
        .triplet ({acc_lo[1:0], q_m1}),
        .sel     (sel)
    );

    // Pick the Booth multiple; negatives are formed as ~x+1 at full width
    always_comb begin
        term = '0;
        case (sel)
            ZERO:    term = '0;
            POS1:    term = m_ext;
            POS2:    term = m_ext << 1;
            NEG1:    term = ~m_ext + ACC_W'(1);
            NEG2:    term = ~(m_ext << 1) + ACC_W'(1);
            default: term = '0;
        endcase
    end

    // Add into the upper part, then arithmetic-shift the whole register right by 2
    always_comb begin
        sum       = acc_hi + term;
        hi_next   = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
        lo_next   = {sum[1:0], acc_lo[Q_W-1:2]};
        prod_next = 64'({hi_next, lo_next});
    end

    // Control FSM with iteration counter, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            m_ext          <= '0;
            acc_hi         <= '0;
            acc_lo         <= '0;
            q_m1           <= 1'b0;
            bus.product_hi <= '0;
            bus.product_lo <= '0;
            bus.ready      <= 1'b1;
            bus.done       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m_ext     <= ext_m(bus.M);
                        acc_hi    <= '0;
                        acc_lo    <= ext_q(bus.Q);
                        q_m1      <= 1'b0;
                        cnt       <= CNT_W'(N_ITER);
                        bus.ready <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    acc_hi <= hi_next;
                    acc_lo <= lo_next;
                    q_m1   <= acc_lo[1];
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        bus.product_hi <= prod_next[63:32];
                        bus.product_lo <= prod_next[31:0];
                        bus.done       <= 1'b1;
                        bus.ready      <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus.ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_booth_seq.sv
// Self-checking bench for mul_booth_seq: a cycle-level behavioural model built
// on plain 64-bit multiplication, compared against the DUT every cycle, plus
// hand-computed literal products and latencies.
// Honours MUL_SIGNED_EN in the same way as the design.
module tb_mul_booth_seq;

`ifdef MUL_SIGNED_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 17;
`endif

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    mul_booth_seq_if bus ();

    mul_booth_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product from the operand interpretation of this build
    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
        logic [63:0] a;
        logic [63:0] b;
`ifdef MUL_SIGNED_EN
        a = {{32{m[31]}}, m};
        b = {{32{q[31]}}, q};
`else
        a = {32'b0, m};
        b = {32'b0, q};
`endif
        return a * b;
    endfunction

    // Behavioural model: accept when idle, deliver the product LAT cycles later
    logic        mdl_ready = 1'b1;
    logic        mdl_done  = 1'b0;
    logic [31:0] mdl_hi    = '0;
    logic [31:0] mdl_lo    = '0;
    int          mdl_left  = 0;
    logic [63:0] mdl_pend  = '0;
    bit          chk_en    = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mdl_ready <= 1'b1;
            mdl_done  <= 1'b0;
            mdl_hi    <= '0;
            mdl_lo    <= '0;
            mdl_left  <= 0;
        end else begin
            mdl_done <= 1'b0;
            if (mdl_ready) begin
                if (bus.start) begin
                    mdl_pend  <= ref_mul(bus.M, bus.Q);
                    mdl_left  <= LAT;
                    mdl_ready <= 1'b0;
                end
            end else begin
                mdl_left <= mdl_left - 1;
                if (mdl_left == 1) begin
                    mdl_hi    <= mdl_pend[63:32];
                    mdl_lo    <= mdl_pend[31:0];
                    mdl_done  <= 1'b1;
                    mdl_ready <= 1'b1;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check_output("ready", 64'(bus.ready), 64'(mdl_ready));
            check_output("done",  64'(bus.done),  64'(mdl_done));
            check_output("hi",    64'(bus.product_hi), 64'(mdl_hi));
            check_output("lo",    64'(bus.product_lo), 64'(mdl_lo));
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (bus.ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.ready !== 1'b1) check_output("wait_ready_timeout", 64'(bus.ready), 64'd1);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (cycles < 40) begin
            @(negedge clk);
            cycles++;
            bus.M = $urandom;
            bus.Q = $urandom;
            if (bus.done === 1'b1) break;
        end
    endtask

    // One directed operation with literal expectations on result and latency
    task automatic apply_stimulus(input logic [31:0] m, input logic [31:0] q,
                                  input logic [63:0] lit, input string name);
        int cycles;
        wait_ready();
        bus.start = 1'b1;
        bus.M     = m;
        bus.Q     = q;
        @(negedge clk);
        bus.start = 1'b0;
        bus.M     = $urandom;
        bus.Q     = $urandom;
        wait_done(cycles);
        check_output({name, "_latency"}, 64'(cycles), 64'(LAT));
        check_output({name, "_dut"}, {bus.product_hi, bus.product_lo}, lit);
        check_output({name, "_model"}, {mdl_hi, mdl_lo}, lit);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cycles;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.M     = '0;
        bus.Q     = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check_output("reset_ready", 64'(bus.ready), 64'd1);
        check_output("reset_done",  64'(bus.done),  64'd0);
        check_output("reset_prod",  {bus.product_hi, bus.product_lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

`ifdef MUL_SIGNED_EN
        apply_stimulus(32'd7, 32'd3, 64'h0000_0000_0000_0015, "s_7x3");
        apply_stimulus(32'hFFFF_FFFB, 32'd6, 64'hFFFF_FFFF_FFFF_FFE2, "s_m5x6");
        apply_stimulus(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "s_min_sq");
        apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "s_m1_sq");
`else
        apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "u_max_sq");
        apply_stimulus(32'd7, 32'd3, 64'h0000_0000_0000_0015, "u_7x3");
        apply_stimulus(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "u_msb_sq");
`endif
        apply_stimulus(32'd0, 32'd12345, 64'd0, "zero_m");

        // Start pulsed while busy must be ignored
        wait_ready();
        bus.start = 1'b1;
        bus.M     = 32'd100;
        bus.Q     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.M     = 32'd9;
        bus.Q     = 32'd9;
        check_output("busy_ready", 64'(bus.ready), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(cycles);
        check_output("busy_done_seen", 64'(bus.done), 64'd1);
        check_output("busy_result", {bus.product_hi, bus.product_lo}, 64'd300);
        repeat (20) @(negedge clk);
        check_output("busy_no_rerun_ready", 64'(bus.ready), 64'd1);
        check_output("busy_no_rerun_prod", {bus.product_hi, bus.product_lo}, 64'd300);

        // Reset in the middle of an operation discards it
        wait_ready();
        bus.start = 1'b1;
        bus.M     = 32'd123;
        bus.Q     = 32'd456;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("midrst_ready", 64'(bus.ready), 64'd1);
        check_output("midrst_done",  64'(bus.done),  64'd0);
        check_output("midrst_prod",  {bus.product_hi, bus.product_lo}, 64'd0);
        apply_stimulus(32'd55, 32'd10, 64'd550, "after_rst");

        // Reset and start on the same edge: reset wins
        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        check_output("rst_vs_start_ready", 64'(bus.ready), 64'd1);

        // Randomized traffic: start held or toggled, operands churn every cycle,
        // occasional resets; the model tracks acceptance and back-to-back runs
        for (int i = 0; i < 900; i++) begin
            bus.start = ($urandom_range(0, 3) != 0);
            bus.M     = pick();
            bus.Q     = pick();
            reset     = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
